// File: rtl/axioma_sysctrl_regs.sv
// System-control register file (CLKPR, WDTCSR, SMCR, MCUSR) feeding axioma_clock_system.
// Handles the timed-change windows, WDR stretching and the sleep entry/exit FSM.
//
// state  | meaning
// AWAKE  | core running, SMCR writable
// ASLEEP | core asleep, SMCR frozen, waiting for wake_event
module axioma_sysctrl_regs #(
  parameter int         WINDOW_CYCLES = 4,
  parameter int         WDR_STRETCH   = 256,
  parameter logic [7:0] ADDR_WDTCSR   = 8'h60,
  parameter logic [7:0] ADDR_CLKPR    = 8'h61,
  parameter logic [7:0] ADDR_SMCR     = 8'h53,
  parameter logic [7:0] ADDR_MCUSR    = 8'h54
) (
  input  logic       clk_ext,
  input  logic       power_on_reset_n,
  input  logic [7:0] bus_addr,
  input  logic       bus_wr,
  input  logic       bus_rd,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  input  logic       wdr_exec,
  input  logic       sleep_exec,
  input  logic       wake_event,
  input  logic       wdt_irq_event,
  input  logic       wdt_irq_ack,
  input  logic [3:0] fuse_cksel,
  input  logic       fuse_ckdiv8,
  input  logic       fuse_wdton,
  input  logic [7:0] mcusr_in,
  output logic [3:0] clock_select,
  output logic [3:0] clock_prescaler,
  output logic       wdt_enable,
  output logic [3:0] wdt_prescaler,
  output logic       wdt_reset_req,
  output logic       wdt_irq,
  output logic       sleep_enable,
  output logic [2:0] sleep_mode,
  output logic [7:0] mcusr_clr
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int CNT_W = $clog2(WDR_STRETCH + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WDR_STRETCH);

  typedef enum logic {
    AWAKE  = 1'b0,
    ASLEEP = 1'b1
  } sleep_state_t;

  sleep_state_t state, state_n;

  logic [3:0]       clkps, clkps_n;
  logic [WIN_W-1:0] clk_win, clk_win_n;
  logic [WIN_W-1:0] wdt_win, wdt_win_n;
  logic             wdif, wdif_n;
  logic             wdie, wdie_n;
  logic             wde, wde_n;
  logic [3:0]       wdp, wdp_n;
  logic [CNT_W-1:0] wdr_cnt, wdr_cnt_n;
  logic [2:0]       sm, sm_n;
  logic             se, se_n;
  logic [7:0]       mcusr_clr_n;
  logic             cksel_done;

  logic wr_clkpr, wr_wdtcsr, wr_smcr, wr_mcusr;
  logic wde_forced;

  assign wr_clkpr   = bus_wr && (bus_addr == ADDR_CLKPR);
  assign wr_wdtcsr  = bus_wr && (bus_addr == ADDR_WDTCSR);
  assign wr_smcr    = bus_wr && (bus_addr == ADDR_SMCR);
  assign wr_mcusr   = bus_wr && (bus_addr == ADDR_MCUSR);
  assign wde_forced = fuse_wdton || mcusr_in[2];

  always_comb begin
    clkps_n   = clkps;
    clk_win_n = (clk_win != '0) ? clk_win - WIN_W'(1) : '0;
    if (wr_clkpr) begin
      if (bus_wdata == 8'h80) begin
        clk_win_n = WIN_LOAD;
      end else if (!bus_wdata[7] && (clk_win != '0)) begin
        clkps_n   = (bus_wdata[3:0] > 4'd8) ? 4'd8 : bus_wdata[3:0];
        clk_win_n = '0;
      end
    end

    wdif_n    = wdif;
    wdie_n    = wdie;
    wde_n     = wde;
    wdp_n     = wdp;
    wdt_win_n = (wdt_win != '0) ? wdt_win - WIN_W'(1) : '0;
    if (wr_wdtcsr) begin
      if (bus_wdata[4] && bus_wdata[3]) begin
        wdt_win_n = WIN_LOAD;
        wdie_n    = bus_wdata[6];
        wde_n     = 1'b1;
      end else if (!bus_wdata[4] && (wdt_win != '0)) begin
        wde_n     = bus_wdata[3];
        wdie_n    = bus_wdata[6];
        wdp_n     = {bus_wdata[5], bus_wdata[2:0]};
        wdt_win_n = '0;
      end else begin
        wdie_n = bus_wdata[6];
        wde_n  = wde | bus_wdata[3];
      end
    end
    if ((wr_wdtcsr && bus_wdata[7]) || wdt_irq_ack) wdif_n = 1'b0;
    // The event set outranks any clear in the same cycle; interrupt-then-reset drops WDIE.
    if (wdt_irq_event) begin
      wdif_n = 1'b1;
      if (wdie && wde) wdie_n = 1'b0;
    end
    if (wde_forced) wde_n = 1'b1;

    wdr_cnt_n = (wdr_cnt != '0) ? wdr_cnt - CNT_W'(1) : '0;
    if (wdr_exec || (wdp_n != wdp)) wdr_cnt_n = CNT_LOAD;

    sm_n = sm;
    se_n = se;
    if (wr_smcr && (state == AWAKE)) begin
      sm_n = bus_wdata[3:1];
      se_n = bus_wdata[0];
    end

    mcusr_clr_n = wr_mcusr ? ~bus_wdata : 8'h00;
  end

  always_comb begin
    state_n = state;
    case (state)
      AWAKE:
        if (sleep_exec && se && (sm != 3'b100) && (sm != 3'b101) && !wake_event)
          state_n = ASLEEP;
      ASLEEP:
        if (wake_event) state_n = AWAKE;
      default: state_n = AWAKE;
    endcase
  end

  always_ff @(posedge clk_ext or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state <= AWAKE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_ext or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      clkps         <= fuse_ckdiv8 ? 4'b0011 : 4'b0000;
      clk_win       <= '0;
      wdt_win       <= '0;
      wdif          <= 1'b0;
      wdie          <= 1'b0;
      wde           <= wde_forced;
      wdp           <= 4'h0;
      wdr_cnt       <= '0;
      sm            <= 3'b000;
      se            <= 1'b0;
      mcusr_clr     <= 8'h00;
      wdt_enable    <= wde_forced;
      wdt_reset_req <= 1'b0;
      wdt_irq       <= 1'b0;
      clock_select  <= 4'h0;
      cksel_done    <= 1'b0;
    end else begin
      clkps         <= clkps_n;
      clk_win       <= clk_win_n;
      wdt_win       <= wdt_win_n;
      wdif          <= wdif_n;
      wdie          <= wdie_n;
      wde           <= wde_n;
      wdp           <= wdp_n;
      wdr_cnt       <= wdr_cnt_n;
      sm            <= sm_n;
      se            <= se_n;
      mcusr_clr     <= mcusr_clr_n;
      wdt_enable    <= wde_n | wdie_n | fuse_wdton;
      wdt_reset_req <= (wdr_cnt_n != '0);
      wdt_irq       <= wdif_n & wdie_n;
      if (!cksel_done) begin
        clock_select <= fuse_cksel;
        cksel_done   <= 1'b1;
      end
    end
  end

  assign clock_prescaler = clkps;
  assign wdt_prescaler   = wdp;
  assign sleep_mode      = sm;
  assign sleep_enable    = (state == ASLEEP);

  always_comb begin
    bus_rdata = 8'h00;
    if (bus_rd) begin
      case (bus_addr)
        ADDR_CLKPR:  bus_rdata = {(clk_win != '0), 3'b000, clkps};
        ADDR_WDTCSR: bus_rdata = {wdif, wdie, wdp[3], (wdt_win != '0), wde, wdp[2:0]};
        ADDR_SMCR:   bus_rdata = {4'b0000, sm, se};
        ADDR_MCUSR:  bus_rdata = mcusr_in;
        default:     bus_rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_axioma_sysctrl_regs.sv
// Scoreboard bench for axioma_sysctrl_regs: stimulus queues expected values tagged with
// the cycle they must appear in, a monitor pops and compares them on the falling edge.
module tb_axioma_sysctrl_regs;

  localparam logic [7:0] A_WDTCSR = 8'h60;
  localparam logic [7:0] A_CLKPR  = 8'h61;
  localparam logic [7:0] A_SMCR   = 8'h53;
  localparam logic [7:0] A_MCUSR  = 8'h54;

  localparam int S_CKSEL = 0, S_CKPS = 1, S_WEN = 2, S_WDP = 3, S_WREQ = 4;
  localparam int S_WIRQ = 5, S_SLEN = 6, S_SLM = 7, S_MCLR = 8, S_RDATA = 9;

  logic       clk_ext = 1'b0;
  logic       power_on_reset_n;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_wr, bus_rd;
  logic       wdr_exec, sleep_exec, wake_event, wdt_irq_event, wdt_irq_ack;
  logic [3:0] fuse_cksel;
  logic       fuse_ckdiv8, fuse_wdton;
  logic [7:0] mcusr_in;
  logic [3:0] clock_select, clock_prescaler, wdt_prescaler;
  logic       wdt_enable, wdt_reset_req, wdt_irq, sleep_enable;
  logic [2:0] sleep_mode;
  logic [7:0] mcusr_clr;

  axioma_sysctrl_regs dut (
    .clk_ext(clk_ext), .power_on_reset_n(power_on_reset_n),
    .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .wdr_exec(wdr_exec), .sleep_exec(sleep_exec), .wake_event(wake_event),
    .wdt_irq_event(wdt_irq_event), .wdt_irq_ack(wdt_irq_ack),
    .fuse_cksel(fuse_cksel), .fuse_ckdiv8(fuse_ckdiv8), .fuse_wdton(fuse_wdton),
    .mcusr_in(mcusr_in), .clock_select(clock_select), .clock_prescaler(clock_prescaler),
    .wdt_enable(wdt_enable), .wdt_prescaler(wdt_prescaler), .wdt_reset_req(wdt_reset_req),
    .wdt_irq(wdt_irq), .sleep_enable(sleep_enable), .sleep_mode(sleep_mode),
    .mcusr_clr(mcusr_clr)
  );

  always #5 clk_ext = ~clk_ext;

  typedef struct packed {
    int         cyc;
    int         sig;
    logic [7:0] val;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tag = 0;
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;
  logic done_seen = 1'b0;
  exp_t e;
  logic [7:0] got;

  always @(posedge clk_ext) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      S_CKSEL: return "clock_select";
      S_CKPS:  return "clock_prescaler";
      S_WEN:   return "wdt_enable";
      S_WDP:   return "wdt_prescaler";
      S_WREQ:  return "wdt_reset_req";
      S_WIRQ:  return "wdt_irq";
      S_SLEN:  return "sleep_enable";
      S_SLM:   return "sleep_mode";
      S_MCLR:  return "mcusr_clr";
      default: return "bus_rdata";
    endcase
  endfunction

  function automatic logic [7:0] sample(input int s);
    case (s)
      S_CKSEL: return {4'h0, clock_select};
      S_CKPS:  return {4'h0, clock_prescaler};
      S_WEN:   return {7'h0, wdt_enable};
      S_WDP:   return {4'h0, wdt_prescaler};
      S_WREQ:  return {7'h0, wdt_reset_req};
      S_WIRQ:  return {7'h0, wdt_irq};
      S_SLEN:  return {7'h0, sleep_enable};
      S_SLM:   return {5'h0, sleep_mode};
      S_MCLR:  return mcusr_clr;
      default: return bus_rdata;
    endcase
  endfunction

  always @(negedge clk_ext) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s #%0d not sampled in cycle %0d (now %0d)", sig_name(e.sig), e.tag, e.cyc, cyc);
      end else begin
        got = sample(e.sig);
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s #%0d cycle %0d: got %h expected %h", sig_name(e.sig), e.tag, cyc, got, e.val);
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
    end
  end

  task automatic push(input int dc, input int sig, input logic [7:0] val);
    exp_t n;
    int   i;
    n.cyc = cyc + dc;
    n.sig = sig;
    n.val = val;
    n.tag = tag;
    tag++;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= n.cyc) i++;
    sb.insert(i, n);
  endtask

  task automatic cw();
    @(posedge clk_ext);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cw();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    cw();
    bus_wr    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] v);
    bus_addr = a;
    bus_rd   = 1'b1;
    push(0, S_RDATA, v);
    cw();
    bus_rd   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    power_on_reset_n = 1'b0;
    bus_addr = 8'h00; bus_wdata = 8'h00; bus_wr = 1'b0; bus_rd = 1'b0;
    wdr_exec = 1'b0; sleep_exec = 1'b0; wake_event = 1'b0;
    wdt_irq_event = 1'b0; wdt_irq_ack = 1'b0;
    fuse_cksel = 4'hA; fuse_ckdiv8 = 1'b1; fuse_wdton = 1'b0; mcusr_in = 8'h00;

    // T1: reset values and clock_select capture
    cw();
    push(0, S_CKPS, 8'h03);
    push(0, S_CKSEL, 8'h00);
    push(0, S_WEN, 8'h00);
    push(0, S_WREQ, 8'h00);
    push(0, S_SLEN, 8'h00);
    push(0, S_MCLR, 8'h00);
    idle(2);
    power_on_reset_n = 1'b1;
    push(0, S_CKSEL, 8'h00);
    push(1, S_CKSEL, 8'h0A);
    push(1, S_CKPS, 8'h03);
    cw();
    fuse_cksel = 4'h5;
    push(2, S_CKSEL, 8'h0A);
    cw();
    rd(A_CLKPR, 8'h03);

    // T2: CLKPR window
    wr(A_CLKPR, 8'h80);
    rd(A_CLKPR, 8'h83);
    idle(1);
    wr(A_CLKPR, 8'h02);
    push(0, S_CKPS, 8'h02);
    rd(A_CLKPR, 8'h02);
    wr(A_CLKPR, 8'h80);
    idle(4);
    wr(A_CLKPR, 8'h01);
    push(0, S_CKPS, 8'h02);
    rd(A_CLKPR, 8'h02);
    wr(A_CLKPR, 8'h80);
    wr(A_CLKPR, 8'h0F);
    push(0, S_CKPS, 8'h08);
    wr(A_CLKPR, 8'h80);
    idle(3);
    wr(A_CLKPR, 8'h01);
    push(0, S_CKPS, 8'h01);
    wr(A_CLKPR, 8'h80);
    wr(A_CLKPR, 8'h85);
    push(0, S_CKPS, 8'h01);
    wr(A_CLKPR, 8'h04);
    push(0, S_CKPS, 8'h04);

    // T3: WDTCSR timed change and WDP-triggered stretch
    wr(A_WDTCSR, 8'h18);
    push(0, S_WEN, 8'h01);
    push(0, S_WREQ, 8'h00);
    rd(A_WDTCSR, 8'h18);
    wr(A_WDTCSR, 8'h05);
    push(0, S_WEN, 8'h00);
    push(0, S_WDP, 8'h05);
    push(0, S_WREQ, 8'h01);
    push(255, S_WREQ, 8'h01);
    push(256, S_WREQ, 8'h00);
    idle(258);
    rd(A_WDTCSR, 8'h05);

    // T6: interrupt flag, interrupt-then-reset, WDR merge
    wr(A_WDTCSR, 8'h48);
    push(0, S_WEN, 8'h01);
    push(0, S_WDP, 8'h05);
    push(0, S_WIRQ, 8'h00);
    wdt_irq_event = 1'b1; cw(); wdt_irq_event = 1'b0;
    push(0, S_WIRQ, 8'h00);
    rd(A_WDTCSR, 8'h8D);
    wr(A_WDTCSR, 8'h88);
    rd(A_WDTCSR, 8'h0D);
    wr(A_WDTCSR, 8'h18);
    wr(A_WDTCSR, 8'h45);
    push(0, S_WEN, 8'h01);
    push(0, S_WIRQ, 8'h00);
    wdt_irq_event = 1'b1; cw(); wdt_irq_event = 1'b0;
    push(0, S_WIRQ, 8'h01);
    wdt_irq_event = 1'b1; wdt_irq_ack = 1'b1; cw(); wdt_irq_event = 1'b0; wdt_irq_ack = 1'b0;
    push(0, S_WIRQ, 8'h01);
    wdt_irq_ack = 1'b1; cw(); wdt_irq_ack = 1'b0;
    push(0, S_WIRQ, 8'h00);
    rd(A_WDTCSR, 8'h45);
    wdr_exec = 1'b1; cw(); wdr_exec = 1'b0;
    push(0, S_WREQ, 8'h01);
    push(99, S_WREQ, 8'h01);
    idle(99);
    wdr_exec = 1'b1; cw(); wdr_exec = 1'b0;
    push(255, S_WREQ, 8'h01);
    push(256, S_WREQ, 8'h00);
    idle(258);

    // T4: WDRF forces WDE; MCUSR clear pulse
    mcusr_in = 8'h04;
    cw();
    wr(A_WDTCSR, 8'h18);
    wr(A_WDTCSR, 8'h00);
    push(0, S_WEN, 8'h01);
    rd(A_MCUSR, 8'h04);
    wr(A_MCUSR, 8'hFB);
    push(0, S_MCLR, 8'h04);
    push(1, S_MCLR, 8'h00);
    mcusr_in = 8'h00;
    push(1, S_WEN, 8'h01);
    cw();
    wr(A_WDTCSR, 8'h18);
    wr(A_WDTCSR, 8'h00);
    push(0, S_WEN, 8'h00);

    // T5: sleep FSM
    wr(A_SMCR, 8'h05);
    push(0, S_SLM, 8'h02);
    push(0, S_SLEN, 8'h00);
    sleep_exec = 1'b1; cw(); sleep_exec = 1'b0;
    push(0, S_SLEN, 8'h01);
    wr(A_SMCR, 8'h00);
    push(0, S_SLM, 8'h02);
    rd(A_SMCR, 8'h05);
    wake_event = 1'b1; cw(); wake_event = 1'b0;
    push(0, S_SLEN, 8'h00);
    wr(A_SMCR, 8'h09);
    sleep_exec = 1'b1; cw(); sleep_exec = 1'b0;
    push(0, S_SLEN, 8'h00);
    push(1, S_SLEN, 8'h00);
    wr(A_SMCR, 8'h05);
    sleep_exec = 1'b1; wake_event = 1'b1; cw(); sleep_exec = 1'b0; wake_event = 1'b0;
    push(0, S_SLEN, 8'h00);
    wr(A_SMCR, 8'h04);
    sleep_exec = 1'b1; cw(); sleep_exec = 1'b0;
    push(0, S_SLEN, 8'h00);
    rd(A_SMCR, 8'h04);

    // reset mid-stretch, with fuses changed
    fuse_ckdiv8 = 1'b0;
    fuse_wdton  = 1'b1;
    wdr_exec = 1'b1; cw(); wdr_exec = 1'b0;
    push(0, S_WREQ, 8'h01);
    idle(10);
    power_on_reset_n = 1'b0;
    push(0, S_WREQ, 8'h00);
    push(0, S_CKPS, 8'h00);
    push(0, S_CKSEL, 8'h00);
    push(0, S_WEN, 8'h01);
    cw();
    power_on_reset_n = 1'b1;
    push(1, S_WREQ, 8'h00);
    push(1, S_CKSEL, 8'h05);
    push(1, S_WEN, 8'h01);
    idle(3);

    done = 1'b1;
    @(negedge clk_ext);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
